// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module   : serial_subtractor_if
// Brief    : Start/busy/done handshake, operand and flag bundle for
//            serial_subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bout;
  logic         zero;
  logic         ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, zero, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial N-bit subtractor, d = a - b - bin, LSB first,
//            one borrow flip-flop, registered borrow/zero/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_subtractor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_last = CW'(N - 1);

  state_t        r_state;
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [N-1:0]  r_res;
  logic [CW-1:0] r_cnt;
  logic          r_br;
  logic          r_amsb;
  logic          r_bmsb;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_d;
  logic          r_bout;
  logic          r_zero;
  logic          r_ovf;

  logic          w_diff;
  logic          w_br_n;
  logic [N-1:0]  w_res_n;

  assign w_diff  = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_n  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  // Result fills from the MSB end so the last computed bit lands at d[N-1].
  assign w_res_n = {w_diff, r_res[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= bus.bin;
            r_amsb  <= bus.a[N-1];
            r_bmsb  <= bus.b[N-1];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sa  <= {1'b0, r_sa[N-1:1]};
          r_sb  <= {1'b0, r_sb[N-1:1]};
          r_res <= w_res_n;
          r_br  <= w_br_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_d     <= w_res_n;
            r_bout  <= w_br_n;
            r_zero  <= (w_res_n == '0);
            r_ovf   <= (r_amsb ^ r_bmsb) & (w_diff ^ r_amsb);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.d    = r_d;
  assign bus.bout = r_bout;
  assign bus.zero = r_zero;
  assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed and exhaustive self-checking bench for serial_subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  logic [N-1:0] prev_d;
  logic         prev_bout;

  serial_subtractor_if #(.N(N)) ifc ();

  serial_subtractor #(.N(N), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one operation; optionally re-pulse start with other operands mid-run.
  task automatic do_op(input string tag, input logic [N-1:0] ia, input logic [N-1:0] ib,
                       input logic ibin, input logic [N-1:0] ed, input logic eb,
                       input logic ez, input logic eo, input logic pulse_mid);
    int busy_cyc;
    int i;
    @(negedge clk);
    ifc.a = ia; ifc.b = ib; ifc.bin = ibin; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.a = ~ia; ifc.b = ~ib; ifc.bin = ~ibin;
    busy_cyc = 0;
    for (i = 0; i < 20 && !ifc.done; i++) begin
      if (ifc.busy) busy_cyc++;
      if (ifc.d !== prev_d || ifc.bout !== prev_bout) check({tag, " hold"}, {ifc.bout, ifc.d}, {prev_bout, prev_d});
      if (pulse_mid && i == 1) begin
        ifc.a = 4'b1111; ifc.b = 4'b0000; ifc.bin = 1'b1; ifc.start = 1'b1;
      end else begin
        ifc.start = 1'b0;
      end
      @(negedge clk);
    end
    ifc.start = 1'b0;
    check({tag, " done"}, ifc.done, 1'b1);
    check({tag, " busycyc"}, busy_cyc, N);
    check({tag, " d"}, ifc.d, ed);
    check({tag, " bout"}, ifc.bout, eb);
    check({tag, " zero"}, ifc.zero, ez);
    check({tag, " ovf"}, ifc.ovf, eo);
    prev_d = ed; prev_bout = eb;
    @(negedge clk);
    check({tag, " donew"}, ifc.done, 1'b0);
    check({tag, " dhold"}, ifc.d, ed);
    if (pulse_mid) begin
      for (int k = 0; k < N + 2; k++) begin
        @(negedge clk);
        check({tag, " noq"}, {ifc.busy, ifc.done}, 2'b00);
      end
    end
  endtask

  initial begin
    logic [N:0] full;
    int         sr;
    n_vec = 0; n_miss = 0;
    prev_d = '0; prev_bout = 1'b0;
    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst", {ifc.busy, ifc.done, ifc.bout, ifc.zero, ifc.ovf, ifc.d}, '0);
    rst_n = 1'b1;

    do_op("t1", 4'b0101, 4'b1111, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("t2", 4'b1011, 4'b1110, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("t3", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("t4", 4'b1010, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("t5", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("t6", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("t7", 4'b1000, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-run discards the operation
    @(negedge clk);
    ifc.a = 4'b0101; ifc.b = 4'b0011; ifc.bin = 1'b0; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid", {ifc.busy, ifc.done, ifc.bout, ifc.zero, ifc.ovf, ifc.d}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_d = '0; prev_bout = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      check("rstnodone", {ifc.busy, ifc.done, ifc.d}, '0);
    end

    for (int v = 0; v < (1 << (2 * N + 1)); v++) begin
      logic [N-1:0] va, vb;
      logic         vbin;
      va   = v[N-1:0];
      vb   = v[2*N-1:N];
      vbin = v[2*N];
      full = {1'b0, va} - {1'b0, vb} - {{N{1'b0}}, vbin};
      sr   = $signed({va[N-1], va}) - $signed({vb[N-1], vb}) - int'(vbin);
      do_op("sweep", va, vb, vbin, full[N-1:0], full[N], full[N-1:0] == '0,
            (sr > 7) || (sr < -8), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor for the processor datapath. It is the inverse-operation counterpart of the existing ripple-carry adder.
- Computes d = a − b − bin, processing one bit per clock, LSB first, with a single borrow flip-flop.
- Provides a start/busy/done handshake and registered flags (borrow, zero, signed overflow) for the ALU/flag logic.
- Trades N cycles of latency for minimal area versus a parallel subtractor.

Parameters:
- N, 4, operand/result width in bits (N ≥ 2).
- CW, 3, bit-counter width; must satisfy 2^CW ≥ N.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  minuend (two's complement or unsigned), sampled with start.
- b  input  N  subtrahend, sampled with start.
- bin  input  1  borrow-in, sampled with start.
- busy  output  1  high while operation in progress (RUN).
- done  output  1  one-cycle pulse when results update.
- d  output  N  difference, registered.
- bout  output  1  borrow-out (1 ⇔ unsigned a < b + bin).
- zero  output  1  d == 0.
- ovf  output  1  signed overflow.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-operation):
  - state = IDLE; shift registers, counter and borrow FF cleared.
  - busy = 0, done = 0, d = 0, bout = 0, zero = 0, ovf = 0.
  - Any in-flight operation is discarded; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On edge with start = 1: latch a into sa and b into sb, load borrow FF = bin, count = 0, go to RUN.
  - Also latch a[N-1] and b[N-1] for overflow.
- RUN (busy = 1), each edge:
  - Compute bit: diff = sa[0] ^ sb[0] ^ br.
  - Next borrow: br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - Shift sa and sb right by 1.
  - Shift diff into the result shift register at the MSB end.
  - br = br_n; count++.
  - On the edge where count == N-1 (the Nth RUN edge), go to DONE and update outputs:
    - d = full result (the final diff bit enters as MSB);
    - bout = br_n;
    - zero = (d == 0);
    - ovf = (a_msb ^ b_msb) & (d[N-1] ^ a_msb).
- DONE (done = 1, busy = 0): unconditionally return to IDLE on the next edge.
- Latency: start sampled at edge k → outputs valid and done = 1 in the cycle after edge k+N. Throughput: one operation per N+2 cycles.
- start while in RUN or DONE is ignored: no queuing, operands not resampled.
- a, b, bin may change freely after the start edge without affecting the result.
- d, bout, zero, ovf hold their values between completions. They change only on the completing edge or on reset.
- bin = 1 with a = b = 0 → d = all ones, bout = 1 (wrap-around).
- Result is exactly (a − b − bin) mod 2^N. bout is identical to a parallel subtractor's borrow.

Test Plan:
- Reset: assert rst_n = 0 mid-RUN (e.g. cycle 2 of 0101 − 0011) → all outputs 0 immediately, state IDLE, no done pulse after release.
- a = 0101, b = 1111, bin = 0, start → done after N+1 = 5 edges; d = 0110, bout = 1, zero = 0, ovf = 0.
- a = 1011, b = 1110, bin = 0 → d = 1101, bout = 1, ovf = 0. Then a = 0111, b = 1000 → d = 1111, bout = 1, ovf = 1.
- a = 1010, b = 1010 → d = 0000, zero = 1, bout = 0. Then a = 0000, b = 0000, bin = 1 → d = 1111, bout = 1, zero = 0.
- Pulse start again 2 cycles into an op (a = 0101, b = 0011) with different operands → ignored; d = 0010, exactly one done pulse; busy high for exactly N cycles.
- Random sweep of all 2^(2N+1) inputs for N = 4 against a reference model (a − b − bin); also check done is exactly one cycle wide and outputs are stable between completions.
